// File: rtl/drv_act_led_stretch.sv
// Purpose : stretch per-drive SGPIO activity bits into visible ON pulses followed by a
//           minimum OFF gap; a frame watchdog blanks every activity LED when frames stop.
// Latency : request (FRAME_VALID & ACT_RAW[i]) at cycle N -> FSM ON at N+1 -> LED lit at N+2.
// Backpressure: none. Frames are sampled on every FRAME_VALID pulse. A request during ON/GAP
//           queues at most one further pulse.
//
// Ports:
//   SYSCLK       system clock
//   RESET        synchronous reset, active-high
//   FRAME_VALID  one-cycle pulse: ACT_RAW holds a complete new frame this cycle
//   ACT_RAW      per-drive activity bit (1 = active), only looked at with FRAME_VALID
//   LAMP_TEST    1 = light every LED (FSMs and watchdog keep running untouched)
//   ACT_LED_L    registered active-low LED cathodes (0 = lit)
//   SGPIO_TMO    registered: 1 = no frame for TMO_TICKS ticks
module drv_act_led_stretch #(
  parameter int NUM_DRV   = 36,
  parameter int TICK_DIV  = 25000,
  parameter int ON_TICKS  = 50,
  parameter int OFF_TICKS = 50,
  parameter int TMO_TICKS = 1000
) (
  input  logic               SYSCLK,
  input  logic               RESET,
  input  logic               FRAME_VALID,
  input  logic [NUM_DRV-1:0] ACT_RAW,
  input  logic               LAMP_TEST,
  output logic [NUM_DRV-1:0] ACT_LED_L,
  output logic               SGPIO_TMO
);

  // ------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // ------------------------------------------------------------------
  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("drv_act_led_stretch: TICK_DIV must be >= 2");
  end
  if (ON_TICKS < 1) begin : g_bad_on_ticks
    $error("drv_act_led_stretch: ON_TICKS must be >= 1");
  end
  if (OFF_TICKS < 1) begin : g_bad_off_ticks
    $error("drv_act_led_stretch: OFF_TICKS must be >= 1");
  end
  if (TMO_TICKS < 1) begin : g_bad_tmo_ticks
    $error("drv_act_led_stretch: TMO_TICKS must be >= 1");
  end

  // ------------------------------------------------------------------
  // Widths and constants
  // ------------------------------------------------------------------
  localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);
  localparam int PW        = $clog2(TICK_DIV);
  localparam int WW        = $clog2(TMO_TICKS + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_ON     = CW'(ON_TICKS);
  localparam logic [CW-1:0] CNT_OFF    = CW'(OFF_TICKS);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [WW-1:0] WD_MAX     = WW'(TMO_TICKS);
  localparam logic [WW-1:0] WD_ONE     = WW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } drv_state_e;

  // ------------------------------------------------------------------
  // Tick prescaler: first tick lands on the TICK_DIV-th cycle after reset
  // ------------------------------------------------------------------
  logic [PW-1:0] presc_q;
  logic          tick;

  assign tick = (presc_q == PRESC_LAST);

  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // Frame watchdog. Saturates at TMO_TICKS; the flag follows one edge
  // after the counter reaches its limit. A frame clears both at once.
  // ------------------------------------------------------------------
  logic [WW-1:0] wd_q;

  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      wd_q      <= '0;
      SGPIO_TMO <= 1'b0;
    end else if (FRAME_VALID) begin
      wd_q      <= '0;
      SGPIO_TMO <= 1'b0;
    end else begin
      if (tick && (wd_q != WD_MAX)) begin
        wd_q <= wd_q + WD_ONE;
      end
      if (wd_q == WD_MAX) begin
        SGPIO_TMO <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Per-drive request. Gating with FRAME_VALID keeps stale or undriven
  // ACT_RAW bits out of the FSMs between frames.
  // ------------------------------------------------------------------
  logic [NUM_DRV-1:0] req;

  assign req = {NUM_DRV{FRAME_VALID}} & ACT_RAW;

  // ------------------------------------------------------------------
  // Per-drive stretch FSM: state register
  // ------------------------------------------------------------------
  drv_state_e    state_q [NUM_DRV];
  drv_state_e    state_d [NUM_DRV];
  logic [CW-1:0] cnt_q   [NUM_DRV];
  logic [CW-1:0] cnt_d   [NUM_DRV];
  logic          pend_q  [NUM_DRV];
  logic          pend_d  [NUM_DRV];

  always_ff @(posedge SYSCLK) begin
    for (int i = 0; i < NUM_DRV; i++) begin
      if (RESET) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
        pend_q[i]  <= 1'b0;
      end else begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        pend_q[i]  <= pend_d[i];
      end
    end
  end

  // ------------------------------------------------------------------
  // Per-drive stretch FSM: next state
  //   ON  : fixed-length pulse; a request only queues the next pulse.
  //   GAP : enforced dark time; at its last tick a queued (or same-cycle)
  //         request relaunches ON, otherwise the drive goes idle.
  // While the stream is timed out every drive is flushed to IDLE, unless
  // a frame arrives this cycle, in which case it is processed normally.
  // ------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_DRV; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      pend_d[i]  = pend_q[i];

      if (SGPIO_TMO && !FRAME_VALID) begin
        state_d[i] = ST_IDLE;
        cnt_d[i]   = '0;
        pend_d[i]  = 1'b0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (req[i]) begin
              state_d[i] = ST_ON;
              cnt_d[i]   = CNT_ON;
              pend_d[i]  = 1'b0;
            end
          end

          ST_ON: begin
            if (req[i]) begin
              pend_d[i] = 1'b1;
            end
            if (tick) begin
              if (cnt_q[i] > CNT_ONE) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
              end else begin
                state_d[i] = ST_GAP;
                cnt_d[i]   = CNT_OFF;
              end
            end
          end

          ST_GAP: begin
            if (req[i]) begin
              pend_d[i] = 1'b1;
            end
            if (tick) begin
              if (cnt_q[i] > CNT_ONE) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
              end else if (pend_q[i] || req[i]) begin
                state_d[i] = ST_ON;
                cnt_d[i]   = CNT_ON;
                pend_d[i]  = 1'b0;
              end else begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = '0;
                pend_d[i]  = 1'b0;
              end
            end
          end

          default: begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
            pend_d[i]  = 1'b0;
          end
        endcase
      end
    end
  end

  // ------------------------------------------------------------------
  // Registered active-low LED drive
  // ------------------------------------------------------------------
  always_ff @(posedge SYSCLK) begin
    for (int i = 0; i < NUM_DRV; i++) begin
      if (RESET) begin
        ACT_LED_L[i] <= 1'b1;
      end else begin
        ACT_LED_L[i] <= ~(LAMP_TEST | (state_q[i] == ST_ON));
      end
    end
  end

endmodule

// File: tb/tb_drv_act_led_stretch.sv
module tb_drv_act_led_stretch;

  localparam int NUM_DRV   = 4;
  localparam int TICK_DIV  = 4;
  localparam int ON_TICKS  = 3;
  localparam int OFF_TICKS = 2;
  localparam int TMO_TICKS = 10;

  localparam int P_IDLE = 0;
  localparam int P_ON   = 1;
  localparam int P_GAP  = 2;

  logic               SYSCLK = 1'b0;
  logic               RESET = 1'b1;
  logic               FRAME_VALID = 1'b0;
  logic [NUM_DRV-1:0] ACT_RAW = '0;
  logic               LAMP_TEST = 1'b0;
  logic [NUM_DRV-1:0] ACT_LED_L;
  logic               SGPIO_TMO;

  always #5 SYSCLK = ~SYSCLK;

  drv_act_led_stretch #(
    .NUM_DRV  (NUM_DRV),
    .TICK_DIV (TICK_DIV),
    .ON_TICKS (ON_TICKS),
    .OFF_TICKS(OFF_TICKS),
    .TMO_TICKS(TMO_TICKS)
  ) dut (
    .SYSCLK     (SYSCLK),
    .RESET      (RESET),
    .FRAME_VALID(FRAME_VALID),
    .ACT_RAW    (ACT_RAW),
    .LAMP_TEST  (LAMP_TEST),
    .ACT_LED_L  (ACT_LED_L),
    .SGPIO_TMO  (SGPIO_TMO)
  );

  typedef struct packed {
    logic [NUM_DRV-1:0] led_l;
    logic               tmo;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: each drive remembers its phase and the absolute cycle
  // of the tick that ends that phase; the watchdog is derived from the
  // cycle of the most recent frame.
  int   m_phase [NUM_DRV];
  int   m_end   [NUM_DRV];
  bit   m_pend  [NUM_DRV];
  bit   m_tmo;
  int   m_last_fv;
  int   cyc;

  logic [NUM_DRV-1:0] cur_led;
  logic               cur_tmo;

  // Cycle of the n-th tick strictly after cycle c (ticks at k*TICK_DIV-1, k>=1).
  function automatic int nth_tick(input int c, input int n);
    return ((c + 1) / TICK_DIV + n) * TICK_DIV - 1;
  endfunction

  task automatic model_step(input logic rst, input logic fv,
                            input logic [NUM_DRV-1:0] raw, input logic lamp);
    exp_t e;
    bit   new_tmo;
    bit   req;
    if (rst) begin
      e.led_l = '1;
      e.tmo   = 1'b0;
      for (int i = 0; i < NUM_DRV; i++) begin
        m_phase[i] = P_IDLE;
        m_end[i]   = 0;
        m_pend[i]  = 1'b0;
      end
      m_tmo     = 1'b0;
      m_last_fv = -1;
      cyc       = 0;
    end else begin
      for (int i = 0; i < NUM_DRV; i++) begin
        e.led_l[i] = ~(lamp | (m_phase[i] == P_ON));
      end
      new_tmo = fv ? 1'b0 : (m_tmo || (cyc >= nth_tick(m_last_fv, TMO_TICKS) + 1));
      e.tmo   = new_tmo;
      for (int i = 0; i < NUM_DRV; i++) begin
        req = fv & raw[i];
        if (m_tmo && !fv) begin
          m_phase[i] = P_IDLE;
          m_pend[i]  = 1'b0;
        end else if (m_phase[i] == P_IDLE) begin
          if (req) begin
            m_phase[i] = P_ON;
            m_end[i]   = nth_tick(cyc, ON_TICKS);
            m_pend[i]  = 1'b0;
          end
        end else if (m_phase[i] == P_ON) begin
          if (req) m_pend[i] = 1'b1;
          if (cyc == m_end[i]) begin
            m_phase[i] = P_GAP;
            m_end[i]   = nth_tick(cyc, OFF_TICKS);
          end
        end else begin
          if (cyc == m_end[i]) begin
            if (m_pend[i] || req) begin
              m_phase[i] = P_ON;
              m_end[i]   = nth_tick(cyc, ON_TICKS);
            end else begin
              m_phase[i] = P_IDLE;
            end
            m_pend[i] = 1'b0;
          end else if (req) begin
            m_pend[i] = 1'b1;
          end
        end
      end
      if (fv) m_last_fv = cyc;
      m_tmo = new_tmo;
      cyc   = cyc + 1;
    end
    sb_q.push_back(e);
  endtask

  // One clock cycle of stimulus: capture the outputs of this cycle, drive
  // inputs, and queue the outputs expected for the following cycle.
  task automatic cycle(input logic rst, input logic fv,
                       input logic [NUM_DRV-1:0] raw, input logic lamp);
    @(negedge SYSCLK);
    cur_led     = ACT_LED_L;
    cur_tmo     = SGPIO_TMO;
    RESET       = rst;
    FRAME_VALID = fv;
    ACT_RAW     = raw;
    LAMP_TEST   = lamp;
    model_step(rst, fv, raw, lamp);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0);
  endtask

  // Directed spot check against values taken straight from the expected timeline.
  task automatic spot(input string nm, input int c,
                      input logic [NUM_DRV-1:0] act, input logic [NUM_DRV-1:0] req);
    checks = checks + 1;
    if (act !== req) begin
      failures = failures + 1;
      $display("FAIL %s cycle=%0d actual=%b required=%b", nm, c, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents outputs, pop and compare.
  initial begin
    exp_t e;
    int   n;
    n = 0;
    forever begin
      @(posedge SYSCLK);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks = checks + 2;
        if (ACT_LED_L !== e.led_l) begin
          failures = failures + 1;
          $display("FAIL sb_led sample=%0d actual=%b required=%b", n, ACT_LED_L, e.led_l);
        end
        if (SGPIO_TMO !== e.tmo) begin
          failures = failures + 1;
          $display("FAIL sb_tmo sample=%0d actual=%b required=%b", n, SGPIO_TMO, e.tmo);
        end
        n = n + 1;
      end
    end
  end

  initial begin
    logic               r_rst, r_fv, r_lamp;
    logic [NUM_DRV-1:0] r_raw;
    int                 quiet, lamp_burst;

    // Single event
    do_reset();
    for (int c = 0; c < 25; c++) begin
      cycle(1'b0, c == 0, 4'b0001, 1'b0);
      if (c >= 2 && c <= 12) spot("single_lit", c, cur_led, 4'b1110);
      else if (c >= 13)      spot("single_dark", c, cur_led, 4'b1111);
    end

    // Pending re-trigger
    do_reset();
    for (int c = 0; c < 31; c++) begin
      cycle(1'b0, (c == 0) || (c == 5), 4'b0001, 1'b0);
      if (c >= 2 && c <= 12)       spot("pend_lit1", c, cur_led, 4'b1110);
      else if (c >= 13 && c <= 20) spot("pend_gap", c, cur_led, 4'b1111);
      else if (c >= 21)            spot("pend_lit2", c, cur_led, 4'b1110);
    end

    // Request on the terminal tick of ON
    do_reset();
    for (int c = 0; c < 31; c++) begin
      cycle(1'b0, (c == 0) || (c == 11), 4'b0010, 1'b0);
      if (c >= 2 && c <= 12)       spot("term_lit1", c, cur_led, 4'b1101);
      else if (c >= 13 && c <= 20) spot("term_gap", c, cur_led, 4'b1111);
      else if (c >= 21)            spot("term_lit2", c, cur_led, 4'b1101);
    end

    // Watchdog timeout and recovery
    do_reset();
    for (int c = 0; c < 56; c++) begin
      cycle(1'b0, (c == 0) || (c == 50), (c == 50) ? 4'b1000 : 4'b0000, 1'b0);
      if (c <= 40)      spot("wd_clear", c, {3'b000, cur_tmo}, 4'b0000);
      else if (c <= 50) spot("wd_tmo", c, {3'b000, cur_tmo}, 4'b0001);
      else              spot("wd_recover", c, {3'b000, cur_tmo}, 4'b0000);
      if (c == 51)      spot("wd_led_dark", c, cur_led, 4'b1111);
      else if (c >= 52) spot("wd_led_lit", c, cur_led, 4'b0111);
    end

    // Timeout flush after continuous traffic
    do_reset();
    for (int c = 0; c < 100; c++) begin
      cycle(1'b0, (c < 40) && (c % 8 == 0), 4'b1111, 1'b0);
      if (c >= 75) begin
        spot("flush_led", c, cur_led, 4'b1111);
        spot("flush_tmo", c, {3'b000, cur_tmo}, 4'b0001);
      end
    end

    // Lamp test
    do_reset();
    for (int c = 0; c < 13; c++) begin
      cycle(1'b0, 1'b0, 4'b0000, (c >= 5) && (c <= 8));
      if (c >= 6 && c <= 9) spot("lamp_on", c, cur_led, 4'b0000);
      else                  spot("lamp_off", c, cur_led, 4'b1111);
    end

    // Reset while drive 0 is lit; prescaler must restart
    do_reset();
    for (int c = 0; c < 5; c++) begin
      cycle(1'b0, c == 0, 4'b0001, 1'b0);
      if (c >= 2) spot("prerst_lit", c, cur_led, 4'b1110);
    end
    cycle(1'b1, 1'b0, 4'b0000, 1'b0);
    for (int c = 0; c < 15; c++) begin
      cycle(1'b0, c == 0, 4'b0001, 1'b0);
      if (c == 0) begin
        spot("rst_led", c, cur_led, 4'b1111);
        spot("rst_tmo", c, {3'b000, cur_tmo}, 4'b0000);
      end else if (c >= 2 && c <= 12) begin
        spot("postrst_lit", c, cur_led, 4'b1110);
      end else if (c >= 13) begin
        spot("postrst_dark", c, cur_led, 4'b1111);
      end
    end

    // Randomized traffic with quiet spells, lamp bursts and occasional resets
    quiet      = 0;
    lamp_burst = 0;
    for (int n = 0; n < 4000; n++) begin
      r_rst = ($urandom_range(0, 599) == 0);
      if (quiet > 0) quiet = quiet - 1;
      else if ($urandom_range(0, 149) == 0) quiet = int'($urandom_range(40, 90));
      r_fv  = (quiet == 0) && ($urandom_range(0, 5) == 0);
      r_raw = NUM_DRV'($urandom());
      if (lamp_burst == 0 && $urandom_range(0, 59) == 0) lamp_burst = int'($urandom_range(1, 6));
      r_lamp = (lamp_burst > 0);
      if (lamp_burst > 0) lamp_burst = lamp_burst - 1;
      cycle(r_rst, r_fv, r_raw, r_lamp);
    end

    repeat (3) @(negedge SYSCLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/drv_act_led_stretch.md
Name: drv_act_led_stretch

Overview:
- Consumes the per-drive raw activity bits that the SGPIO receivers decode each frame.
- Drives the active-low drive-activity LED cathodes.
- Stretches each activity indication into a visible ON pulse, then enforces a minimum OFF gap, so continuous traffic shows as a blink.
- A frame watchdog blanks all activity LEDs when the SGPIO stream stops. One instance sits between each SGPIO receiver and the DRVn_ACT_LED_CATH_L pins.

Parameters:
- NUM_DRV, 36, number of drives served by one SGPIO stream.
- TICK_DIV, 25000, SYSCLK cycles per tick (1 ms at 25 MHz); must be >=2.
- ON_TICKS, 50, ticks the LED stays lit per activity event; must be >=1.
- OFF_TICKS, 50, minimum dark ticks after each ON pulse; must be >=1.
- TMO_TICKS, 1000, ticks without FRAME_VALID before the stream is declared dead; must be >=1.

Ports:
- SYSCLK  input  1  system clock.
- RESET  input  1  synchronous reset, active-high.
- FRAME_VALID  input  1  one-cycle pulse; ACT_RAW holds a complete new SGPIO frame this cycle.
- ACT_RAW  input  NUM_DRV  activity bit per drive, 1 = active; sampled only when FRAME_VALID=1.
- LAMP_TEST  input  1  1 = force every LED lit.
- ACT_LED_L  output  NUM_DRV  registered active-low LED cathodes, 0 = lit.
- SGPIO_TMO  output  1  registered; 1 = no frame seen for TMO_TICKS ticks.

Behaviour:
- Reset (RESET=1 at a SYSCLK edge, including mid-operation):
  - Prescaler=0, watchdog=0, all drives IDLE with count=0 and pend=0.
  - ACT_LED_L = all 1s, SGPIO_TMO=0.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - TICK=1 in the cycle the count equals TICK_DIV-1. The first tick after reset is the TICK_DIV-th cycle.
- Per-drive request: req[i] = FRAME_VALID & ACT_RAW[i].
- Per-drive FSM has states IDLE, ON and GAP, plus a count field and a pend flag. Count width is clog2(max(ON_TICKS,OFF_TICKS)+1).
  - IDLE:
    - req -> ON, count=ON_TICKS, pend=0.
  - ON:
    - req -> pend=1.
    - TICK with count>1 -> count-1.
    - TICK with count==1 -> GAP, count=OFF_TICKS.
  - GAP:
    - req -> pend=1.
    - TICK with count>1 -> count-1.
    - TICK with count==1: if (pend|req) -> ON, count=ON_TICKS, pend=0; else -> IDLE, pend=0.
  - When req and a terminal TICK fall in the same cycle, both take effect. In ON, the drive enters GAP with pend=1. In GAP, the drive re-enters ON.
  - A req during ON never extends the current ON pulse; it only queues the next pulse.
- Watchdog:
  - FRAME_VALID clears it to 0 and SGPIO_TMO to 0 on the next edge.
  - Otherwise it increments on each TICK and saturates at TMO_TICKS.
  - When the watchdog reaches TMO_TICKS, SGPIO_TMO=1 on the following edge. From that edge onward, every drive is forced to IDLE with pend=0 each cycle until a FRAME_VALID arrives.
  - A FRAME_VALID while SGPIO_TMO=1 clears the timeout and is processed normally in the same cycle (req can start ON).
- Output: ACT_LED_L[i] (registered) = ~(LAMP_TEST | state[i]==ON).
  - Latency: req at cycle N -> state ON at N+1 -> ACT_LED_L low at N+2.
  - LAMP_TEST affects outputs one cycle later and does not disturb the FSMs or the watchdog.
- Drives are fully independent. ACT_RAW is ignored when FRAME_VALID=0, and X on ACT_RAW is then harmless.

Test Plan (bench parameters: NUM_DRV=4, TICK_DIV=4, ON_TICKS=3, OFF_TICKS=2, TMO_TICKS=10; RESET released so the prescaler is 0 at cycle 0; ticks at cycles 3, 7, 11, ...):
- Single event: FRAME_VALID with ACT_RAW=4'b0001 at cycle 0 -> ACT_LED_L=4'b1110 from cycle 2 through 12; 4'b1111 from cycle 13; drive 0 back in IDLE at cycle 20.
- Pending re-trigger: as above, plus FRAME_VALID with ACT_RAW=4'b0001 at cycle 5 -> LED low cycles 2..12, high 13..20, low again from cycle 21 (the GAP ends at tick 19 and re-enters ON at cycle 20).
- Same-cycle terminal tick: FRAME_VALID with ACT_RAW=4'b0010 at cycles 0 and 11 -> drive 1 enters GAP at 12 with pend=1 and relights at cycle 21. Drives 0, 2 and 3 stay dark throughout.
- Watchdog: single FRAME_VALID at cycle 0 with ACT_RAW=0, then none -> SGPIO_TMO=1 from cycle 41 (10th tick at cycle 39; flag set on the following edge). A FRAME_VALID with ACT_RAW=4'b1000 at cycle 50 -> SGPIO_TMO=0 at 51 and ACT_LED_L[3]=0 at 52.
- Timeout flush: ACT_RAW=4'b1111 on FRAME_VALID every 8 cycles, then frames stop -> all LEDs dark once SGPIO_TMO=1, with no queued pulse firing afterwards.
- Lamp test and reset: LAMP_TEST=1 for cycles 5..8 with no activity -> ACT_LED_L=0 during 6..9. RESET asserted for one cycle while drive 0 is in ON -> ACT_LED_L=all 1s and SGPIO_TMO=0 the next cycle, prescaler restarts at 0.
